leitor_caminho_stream: RTL

//  Parametrised successor to the predecessor-memory path readout. After a search completes, walks the

---
 rtl/leitor_caminho_stream.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/leitor_caminho_stream.sv
// Predecessor-chain path reader: walks anterior[] from destino back to fonte and
// streams every node out, either in walk order or reversed through an internal LIFO.
module leitor_caminho_stream #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned MAX_PATH_LEN = 256,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned LEN_WIDTH    = $clog2(MAX_PATH_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  input  logic                  reverse_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_out,
  input  logic [ADDR_WIDTH-1:0] mem_rd_data_in,
  output logic                  path_valid_out,
  output logic [ADDR_WIDTH-1:0] path_data_out,
  output logic                  path_last_out,
  input  logic                  path_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  erro_out,
  output logic [LEN_WIDTH-1:0]  comprimento_out
);

  localparam int unsigned PTR_W = (MAX_PATH_LEN > 1) ? $clog2(MAX_PATH_LEN) : 1;
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FWD_EMIT = 4'd1;
  localparam logic [3:0] S_FWD_READ = 4'd2;
  localparam logic [3:0] S_FWD_WAIT = 4'd3;
  localparam logic [3:0] S_REV_PUSH = 4'd4;
  localparam logic [3:0] S_REV_READ = 4'd5;
  localparam logic [3:0] S_REV_WAIT = 4'd6;
  localparam logic [3:0] S_REV_POP  = 4'd7;
  localparam logic [3:0] S_ERR      = 4'd8;

  logic [3:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] cur_q,     cur_d;
  logic [ADDR_WIDTH-1:0] fonte_q,   fonte_d;
  logic [LEN_WIDTH-1:0]  len_q,     len_d;
  logic [LEN_WIDTH-1:0]  sp_q,      sp_d;
  logic [LAT_W-1:0]      lat_q,     lat_d;
  logic                  rd_en_q,   rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  valid_q,   valid_d;
  logic [ADDR_WIDTH-1:0] data_q,    data_d;
  logic                  last_q,    last_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  erro_q,    erro_d;
  logic                  push_c;

  logic [ADDR_WIDTH-1:0] lifo_q [MAX_PATH_LEN];

  // Next-state and next-output logic; done/busy change at the edge that completes the last transfer
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    fonte_d   = fonte_q;
    len_d     = len_q;
    sp_d      = sp_q;
    lat_d     = lat_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    erro_d    = erro_q;
    push_c    = 1'b0;

    case (state_q)
      S_IDLE, S_ERR: begin
        state_d = S_IDLE;
        if (start_in) begin
          cur_d   = destino_in;
          fonte_d = fonte_in;
          len_d   = LEN_WIDTH'(1);
          sp_d    = '0;
          busy_d  = 1'b1;
          erro_d  = 1'b0;
          if (reverse_in) begin
            state_d = S_REV_PUSH;
          end else begin
            state_d = S_FWD_EMIT;
            valid_d = 1'b1;
            data_d  = destino_in;
            last_d  = (destino_in == fonte_in);
          end
        end
      end

      S_FWD_EMIT: begin
        if (path_ready_in) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = S_FWD_READ;
            rd_en_d   = 1'b1;
            rd_addr_d = cur_q;
          end
        end
      end

      S_FWD_READ, S_REV_READ: begin
        lat_d   = LAT_W'(1);
        state_d = (state_q == S_FWD_READ) ? S_FWD_WAIT : S_REV_WAIT;
      end

      S_FWD_WAIT, S_REV_WAIT: begin
        if (lat_q != LAT_W'(RD_LAT)) begin
          lat_d = lat_q + LAT_W'(1);
        end else if ((mem_rd_data_in == cur_q) || (len_q >= LEN_WIDTH'(MAX_PATH_LEN))) begin
          // self-loop or over-long chain: abort the walk and drop anything stacked
          state_d = S_ERR;
          busy_d  = 1'b0;
          erro_d  = 1'b1;
          sp_d    = '0;
        end else begin
          cur_d = mem_rd_data_in;
          len_d = len_q + LEN_WIDTH'(1);
          if (state_q == S_FWD_WAIT) begin
            state_d = S_FWD_EMIT;
            valid_d = 1'b1;
            data_d  = mem_rd_data_in;
            last_d  = (mem_rd_data_in == fonte_q);
          end else begin
            state_d = S_REV_PUSH;
          end
        end
      end

      S_REV_PUSH: begin
        if (cur_q == fonte_q) begin
          // fonte goes straight to the output register as the first beat
          state_d = S_REV_POP;
          valid_d = 1'b1;
          data_d  = cur_q;
          last_d  = (sp_q == '0);
        end else begin
          push_c    = 1'b1;
          sp_d      = sp_q + LEN_WIDTH'(1);
          state_d   = S_REV_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = cur_q;
        end
      end

      S_REV_POP: begin
        if (path_ready_in) begin
          if (last_q) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = lifo_q[PTR_W'(sp_q - LEN_WIDTH'(1))];
            sp_d   = sp_q - LEN_WIDTH'(1);
            last_d = (sp_q == LEN_WIDTH'(1));
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      fonte_q   <= '0;
      len_q     <= '0;
      sp_q      <= '0;
      lat_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      fonte_q   <= fonte_d;
      len_q     <= len_d;
      sp_q      <= sp_d;
      lat_q     <= lat_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  // Reverse-order storage; emptiness is tracked by sp_q alone
  always_ff @(posedge clk) begin
    if (push_c) begin
      lifo_q[PTR_W'(sp_q)] <= cur_q;
    end
  end

  assign mem_rd_en_out   = rd_en_q;
  assign mem_rd_addr_out = rd_addr_q;
  assign path_valid_out  = valid_q;
  assign path_data_out   = data_q;
  assign path_last_out   = last_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign erro_out        = erro_q;
  assign comprimento_out = len_q;

endmodule
